// File: rtl/mapper_pkg.sv
// Shared constants for the MMC3-family mappers: CPU register decode,
// bank register indices, PRG quadrant selection and SDRAM region layout.
package mapper_pkg;

  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  // CPU register decode on {A14, A13, A0} within $8000-$FFFF
  localparam logic [2:0] CPU_BANK_SELECT = 3'b000;
  localparam logic [2:0] CPU_BANK_DATA   = 3'b001;
  localparam logic [2:0] CPU_MIRROR      = 3'b010;
  localparam logic [2:0] CPU_RAM_CTRL    = 3'b011;
  localparam logic [2:0] CPU_IRQ_LATCH   = 3'b100;
  localparam logic [2:0] CPU_IRQ_RELOAD  = 3'b101;
  localparam logic [2:0] CPU_IRQ_DISABLE = 3'b110;
  localparam logic [2:0] CPU_IRQ_ENABLE  = 3'b111;

  typedef enum logic [1:0] {
    PSEL_R6,
    PSEL_R7,
    PSEL_2ND_LAST,
    PSEL_LAST
  } prg_sel_e;

  // PRG RAM occupies the top 2^13 bytes of SDRAM.
  localparam int PRG_RAM_SPAN_LOG2 = 13;
  // CHR region base is the SDRAM MSB (ADDR_W - offset).
  localparam int CHR_BASE_MSB_OFFSET = 1;

  function automatic prg_sel_e prg_quadrant(input logic prg_mode, input logic [1:0] quad);
    case (quad)
      2'd0:    return prg_mode ? PSEL_2ND_LAST : PSEL_R6;
      2'd1:    return PSEL_R7;
      2'd2:    return prg_mode ? PSEL_R6 : PSEL_2ND_LAST;
      default: return PSEL_LAST;
    endcase
  endfunction

endpackage

// File: rtl/mmc3_irq_unit.sv
// MMC3-style scanline IRQ: A12 low-time filter, 8-bit reload counter,
// enable/reload control and the registered level IRQ.
module mmc3_irq_unit #(
  parameter int A12_LOW_MIN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       a12,
  input  logic       irq_alt,
  input  logic       wr_latch,
  input  logic       wr_reload,
  input  logic       wr_disable,
  input  logic       wr_enable,
  input  logic [7:0] din,
  output logic       irq
);

  localparam int LOW_W = (A12_LOW_MIN > 0) ? $clog2(A12_LOW_MIN + 1) : 1;
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(A12_LOW_MIN);

  logic [LOW_W-1:0] lowcnt;
  logic             a12_prev;
  logic [7:0]       latch;
  logic [7:0]       counter;
  logic             reload;
  logic             enable;

  logic       clk_event;
  logic [7:0] counter_next;
  logic       fire;

  assign clk_event    = ce && a12 && !a12_prev && (lowcnt == LOW_MAX);
  assign counter_next = ((counter == 8'd0) || reload) ? latch : (counter - 8'd1);
  // Alt (MMC3A) behaviour suppresses the fire when a zero counter simply
  // reloads to a zero latch without an explicit reload request.
  assign fire = clk_event && (counter_next == 8'd0) && enable &&
                (!irq_alt || (counter != 8'd0) || reload);

  always_ff @(posedge clk) begin
    if (reset) begin
      lowcnt   <= '0;
      a12_prev <= 1'b0;
    end else if (ce) begin
      a12_prev <= a12;
      if (a12)
        lowcnt <= '0;
      else if (lowcnt != LOW_MAX)
        lowcnt <= lowcnt + LOW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch   <= 8'd0;
      counter <= 8'd0;
      reload  <= 1'b0;
      enable  <= 1'b0;
      irq     <= 1'b0;
    end else if (ce) begin
      if (wr_latch)
        latch <= din;
      if (clk_event) begin
        counter <= counter_next;
        reload  <= 1'b0;
      end
      // A reload write on an event cycle stays pending for the next event.
      if (wr_reload)
        reload <= 1'b1;
      if (wr_disable)
        enable <= 1'b0;
      else if (wr_enable)
        enable <= 1'b1;
      if (wr_disable)
        irq <= 1'b0;
      else if (fire)
        irq <= 1'b1;
    end
  end

endmodule

// File: rtl/mmc3_gen.sv
// Parametrised MMC3-family mapper: PRG/CHR banking, lockable multicart outer
// bank, optional PRG RAM and a filtered A12 scanline IRQ.
module mmc3_gen
  import mapper_pkg::*;
#(
  parameter int PRG_BANK_W  = 8,
  parameter int CHR_BANK_W  = 8,
  parameter int OUTER_W     = 2,
  parameter int A12_LOW_MIN = 3,
  parameter int ADDR_W      = 22
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    ce,
  input  logic                                    irq_alt,
  input  logic                                    chr_ram,
  input  logic [15:0]                             prg_ain,
  input  logic                                    prg_read,
  input  logic                                    prg_write,
  input  logic [7:0]                              prg_din,
  output logic [ADDR_W-1:0]                       prg_aout,
  output logic                                    prg_allow,
  input  logic [13:0]                             chr_ain,
  output logic [ADDR_W-1:0]                       chr_aout,
  output logic                                    chr_allow,
  output logic                                    vram_a10,
  output logic                                    vram_ce,
  output logic                                    irq,
  output logic [((OUTER_W > 0) ? OUTER_W : 1)-1:0] outer_bank
);

  localparam int PRG_IN_W = PRG_BANK_W - OUTER_W;
  localparam int CHR_IN_W = CHR_BANK_W - OUTER_W;
  localparam int OB_W     = (OUTER_W > 0) ? OUTER_W : 1;
  localparam logic [ADDR_W-1:0] CHR_BASE = ADDR_W'(1) << (ADDR_W - CHR_BASE_MSB_OFFSET);

  logic [2:0]          bank_idx;
  logic                chr_invert;
  logic                prg_mode;
  logic                mirroring;
  logic                ram_enable;
  logic                ram_protect;
  logic [PRG_IN_W-1:0] prg_r6, prg_r7;
  // R0/R1 select 2 KB pairs, so their bit 0 is never stored.
  logic [CHR_IN_W-1:1] chr_r0, chr_r1;
  logic [CHR_IN_W-1:0] chr_r2, chr_r3, chr_r4, chr_r5;
  logic [OB_W-1:0]     outer;

  logic       reg_wr;
  logic [2:0] reg_addr;
  logic       wram_sel;

  assign reg_wr   = ce && prg_write && prg_ain[15];
  assign reg_addr = {prg_ain[14:13], prg_ain[0]};
  assign wram_sel = (prg_ain[15:13] == 3'b011);

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_idx    <= 3'd0;
      chr_invert  <= 1'b0;
      prg_mode    <= 1'b0;
      mirroring   <= 1'b0;
      ram_enable  <= 1'b0;
      ram_protect <= 1'b0;
      prg_r6      <= '0;
      prg_r7      <= '0;
      chr_r0      <= '0;
      chr_r1      <= '0;
      chr_r2      <= '0;
      chr_r3      <= '0;
      chr_r4      <= '0;
      chr_r5      <= '0;
    end else if (reg_wr) begin
      case (reg_addr)
        CPU_BANK_SELECT: begin
          chr_invert <= prg_din[7];
          prg_mode   <= prg_din[6];
          bank_idx   <= prg_din[2:0];
        end
        CPU_BANK_DATA: begin
          case (bank_idx)
            REG_R0: chr_r0 <= (CHR_IN_W-1)'(prg_din[7:1]);
            REG_R1: chr_r1 <= (CHR_IN_W-1)'(prg_din[7:1]);
            REG_R2: chr_r2 <= CHR_IN_W'(prg_din);
            REG_R3: chr_r3 <= CHR_IN_W'(prg_din);
            REG_R4: chr_r4 <= CHR_IN_W'(prg_din);
            REG_R5: chr_r5 <= CHR_IN_W'(prg_din);
            REG_R6: prg_r6 <= PRG_IN_W'(prg_din);
            REG_R7: prg_r7 <= PRG_IN_W'(prg_din);
          endcase
        end
        CPU_MIRROR: mirroring <= prg_din[0];
        CPU_RAM_CTRL: begin
          ram_enable  <= prg_din[7];
          ram_protect <= prg_din[6];
        end
        default: ;
      endcase
    end
  end

  logic [PRG_BANK_W-1:0] prg_bank;
  logic [CHR_BANK_W-1:0] chr_bank;
  logic [PRG_IN_W-1:0]   prg_inner;
  logic [CHR_IN_W-1:0]   chr_inner;

  generate
    if (OUTER_W > 0) begin : g_outer
      logic lock;
      always_ff @(posedge clk) begin
        if (reset) begin
          outer <= '0;
          lock  <= 1'b0;
        end else if (ce && prg_write && wram_sel && !lock) begin
          outer <= prg_din[OUTER_W-1:0];
          lock  <= prg_din[7];
        end
      end
      assign prg_bank = {outer, prg_inner};
      assign chr_bank = {outer, chr_inner};
    end else begin : g_no_outer
      assign outer    = '0;
      assign prg_bank = prg_inner;
      assign chr_bank = chr_inner;
    end
  endgenerate

  always_comb begin
    prg_inner = '1;
    case (prg_quadrant(prg_mode, prg_ain[14:13]))
      PSEL_R6:       prg_inner = prg_r6;
      PSEL_R7:       prg_inner = prg_r7;
      PSEL_2ND_LAST: prg_inner = {{(PRG_IN_W-1){1'b1}}, 1'b0};
      default:       prg_inner = '1;
    endcase
  end

  logic [2:0] chr_slot;
  assign chr_slot = chr_ain[12:10] ^ {chr_invert, 2'b00};

  always_comb begin
    chr_inner = '0;
    case (chr_slot)
      3'd0: chr_inner = {chr_r0, 1'b0};
      3'd1: chr_inner = {chr_r0, 1'b1};
      3'd2: chr_inner = {chr_r1, 1'b0};
      3'd3: chr_inner = {chr_r1, 1'b1};
      3'd4: chr_inner = chr_r2;
      3'd5: chr_inner = chr_r3;
      3'd6: chr_inner = chr_r4;
      3'd7: chr_inner = chr_r5;
    endcase
  end

  logic              ram_hit;
  logic [ADDR_W-1:0] prg_rom_a;
  logic [ADDR_W-1:0] prg_ram_a;

  // With a multicart outer register the $6000 window belongs to it, not RAM.
  assign ram_hit   = (OUTER_W == 0) && wram_sel && ram_enable && !(ram_protect && prg_write);
  assign prg_rom_a = ADDR_W'({prg_bank, prg_ain[12:0]});
  assign prg_ram_a = {{(ADDR_W-PRG_RAM_SPAN_LOG2){1'b1}}, prg_ain[PRG_RAM_SPAN_LOG2-1:0]};

  assign prg_aout   = ram_hit ? prg_ram_a : prg_rom_a;
  assign prg_allow  = (prg_ain[15] && prg_read && !prg_write) || ram_hit;
  assign chr_aout   = CHR_BASE | ADDR_W'({chr_bank, chr_ain[9:0]});
  assign chr_allow  = chr_ram;
  assign vram_a10   = mirroring ? chr_ain[11] : chr_ain[10];
  assign vram_ce    = chr_ain[13];
  assign outer_bank = outer;

  mmc3_irq_unit #(
    .A12_LOW_MIN(A12_LOW_MIN)
  ) u_irq (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .a12       (chr_ain[12]),
    .irq_alt   (irq_alt),
    .wr_latch  (reg_wr && (reg_addr == CPU_IRQ_LATCH)),
    .wr_reload (reg_wr && (reg_addr == CPU_IRQ_RELOAD)),
    .wr_disable(reg_wr && (reg_addr == CPU_IRQ_DISABLE)),
    .wr_enable (reg_wr && (reg_addr == CPU_IRQ_ENABLE)),
    .din       (prg_din),
    .irq       (irq)
  );

endmodule

// File: tb/tb_mmc3_gen.sv
// Bench for mmc3_gen: directed scenarios plus randomized bus/A12 traffic,
// compared every cycle against a behavioural mapper model.
module tb_mmc3_gen;

  localparam int PRG_BANK_W  = 8;
  localparam int CHR_BANK_W  = 8;
  localparam int OUTER_W     = 2;
  localparam int A12_LOW_MIN = 3;
  localparam int ADDR_W      = 22;
  localparam int PRG_IN = 1 << (PRG_BANK_W - OUTER_W);
  localparam int CHR_IN = 1 << (CHR_BANK_W - OUTER_W);
  localparam int OUT_N  = 1 << OUTER_W;

  logic clk = 1'b0;
  logic reset, ce, irq_alt, chr_ram, prg_read, prg_write;
  logic [15:0] prg_ain;
  logic [7:0]  prg_din;
  logic [13:0] chr_ain;
  logic [ADDR_W-1:0] prg_aout, chr_aout;
  logic prg_allow, chr_allow, vram_a10, vram_ce, irq;
  logic [OUTER_W-1:0] outer_bank;

  always #5 clk = ~clk;

  mmc3_gen #(
    .PRG_BANK_W(PRG_BANK_W), .CHR_BANK_W(CHR_BANK_W), .OUTER_W(OUTER_W),
    .A12_LOW_MIN(A12_LOW_MIN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .irq_alt(irq_alt), .chr_ram(chr_ram),
    .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write), .prg_din(prg_din),
    .prg_aout(prg_aout), .prg_allow(prg_allow), .chr_ain(chr_ain), .chr_aout(chr_aout),
    .chr_allow(chr_allow), .vram_a10(vram_a10), .vram_ce(vram_ce), .irq(irq),
    .outer_bank(outer_bank)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_r[8];
  int m_sel, m_inv, m_mode, m_mirror;
  int m_outer, m_lock;
  int m_latch, m_cnt, m_reload, m_en, m_irq;
  bit a12_hist[$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_sel = 0; m_inv = 0; m_mode = 0; m_mirror = 0;
    m_outer = 0; m_lock = 0;
    m_latch = 0; m_cnt = 0; m_reload = 0; m_en = 0; m_irq = 0;
    a12_hist.delete();
  endtask

  function automatic int exp_prg_inner(input int a);
    int q = (a >> 13) & 3;
    if (q == 3) return PRG_IN - 1;
    if (q == 1) return m_r[7];
    if ((q == 0) != (m_mode == 1)) return m_r[6];
    return PRG_IN - 2;
  endfunction

  function automatic int exp_chr_inner(input int a);
    int slot = ((a >> 10) & 7) ^ (m_inv * 4);
    if (slot < 4) return (m_r[slot / 2] & ~1) + (slot % 2);
    return m_r[slot - 2];
  endfunction

  task automatic model_update();
    int a, d, fire, nv, ev;
    if (reset) begin
      model_reset();
      return;
    end
    if (!ce) return;
    a = int'(prg_ain);
    d = int'(prg_din);
    // A qualifying rise needs the last A12_LOW_MIN ce samples all low.
    ev = 0;
    if (chr_ain[12] && a12_hist.size() >= A12_LOW_MIN) begin
      ev = 1;
      for (int i = 0; i < A12_LOW_MIN; i++)
        if (a12_hist[a12_hist.size() - 1 - i]) ev = 0;
    end
    a12_hist.push_back(chr_ain[12]);
    while (a12_hist.size() > A12_LOW_MIN + 1) void'(a12_hist.pop_front());
    fire = 0;
    if (ev) begin
      nv = (m_cnt == 0 || m_reload) ? m_latch : m_cnt - 1;
      fire = (nv == 0) && m_en && (!irq_alt || m_cnt != 0 || m_reload);
      m_cnt = nv;
      m_reload = 0;
    end
    if (fire) m_irq = 1;
    if (prg_write && a >= 'h8000) begin
      case (a & 'hE001)
        'h8000: begin m_inv = (d >> 7) & 1; m_mode = (d >> 6) & 1; m_sel = d & 7; end
        'h8001: m_r[m_sel] = (m_sel >= 6) ? d % PRG_IN : d % CHR_IN;
        'hA000: m_mirror = d & 1;
        'hC000: m_latch = d;
        'hC001: m_reload = 1;
        'hE000: begin m_en = 0; m_irq = 0; end
        'hE001: m_en = 1;
        default: ;
      endcase
    end
    if (prg_write && a >= 'h6000 && a < 'h8000 && !m_lock) begin
      m_outer = d % OUT_N;
      m_lock = (d >> 7) & 1;
    end
  endtask

  task automatic check_comb();
    int pa = int'(prg_ain);
    int ca = int'(chr_ain);
    int exp_allow = (pa >= 'h8000 && prg_read && !prg_write) ? 1 : 0;
    check_eq("prg_allow", 32'(prg_allow), exp_allow);
    if (pa >= 'h8000)
      check_eq("prg_aout", 32'(prg_aout), (m_outer * PRG_IN + exp_prg_inner(pa)) * 8192 + pa % 8192);
    check_eq("chr_aout", 32'(chr_aout),
             (1 << (ADDR_W - 1)) + (m_outer * CHR_IN + exp_chr_inner(ca)) * 1024 + ca % 1024);
    check_eq("chr_allow", 32'(chr_allow), 32'(chr_ram));
    check_eq("vram_ce", 32'(vram_ce), (ca >> 13) & 1);
    check_eq("vram_a10", 32'(vram_a10), m_mirror ? (ca >> 11) & 1 : (ca >> 10) & 1);
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    #1;
    check_eq("irq", 32'(irq), m_irq);
    check_eq("outer_bank", 32'(outer_bank), m_outer);
  endtask

  task automatic idle();
    prg_write = 1'b0;
    prg_read  = 1'b1;
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
    prg_ain = addr; prg_din = data; prg_write = 1'b1; prg_read = 1'b0;
    step();
    idle();
  endtask

  task automatic rd_expect(input string tag, input logic [15:0] addr, input int exp);
    idle();
    prg_ain = addr;
    #1;
    check_eq(tag, 32'(prg_aout), exp);
    step();
  endtask

  task automatic a12_pulse(input int nlow);
    for (int i = 0; i < nlow; i++) begin
      chr_ain[12] = 1'b0;
      step();
    end
    chr_ain[12] = 1'b1;
    step();
  endtask

  task automatic a12_pulse_wr(input int nlow, input logic [15:0] addr, input logic [7:0] data);
    for (int i = 0; i < nlow; i++) begin
      chr_ain[12] = 1'b0;
      step();
    end
    chr_ain[12] = 1'b1;
    cpu_wr(addr, data);
  endtask

  initial begin
    int hold;
    int r;
    logic a12v;
    model_reset();
    reset = 1'b1; ce = 1'b1; irq_alt = 1'b0; chr_ram = 1'b1;
    prg_ain = 16'h8000; prg_din = 8'h00; chr_ain = 14'h0000;
    idle();
    step();
    step();
    reset = 1'b0;
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_outer", 32'(outer_bank), 0);
    rd_expect("rst_prg_last", 16'hE000, 'h07E000);
    rd_expect("rst_prg_2nd", 16'hC000, 'h07C000);

    cpu_wr(16'h8000, 8'h46);
    cpu_wr(16'h8001, 8'h05);
    rd_expect("mode1_c000_r6", 16'hC000, 'h00A000);
    rd_expect("mode1_8000_2nd", 16'h8000, 'h07C000);

    cpu_wr(16'h6000, 8'h82);
    cpu_wr(16'h6000, 8'h01);
    check_eq("outer_locked", 32'(outer_bank), 2);
    rd_expect("outer_prg", 16'hC000, 'h10A000);
    chr_ain = 14'h0000;
    #1;
    check_eq("outer_chr", 32'(chr_aout), 'h220000);
    prg_ain = 16'h6000;
    #1;
    check_eq("wram_absent", 32'(prg_allow), 0);
    step();

    // Latch 3: fires on the 4th valid pulse; a 2-cycle low pulse is ignored
    cpu_wr(16'hC000, 8'd3);
    cpu_wr(16'hC001, 8'd0);
    cpu_wr(16'hE001, 8'd0);
    repeat (3) a12_pulse(3);
    check_eq("irq_after3", 32'(irq), 0);
    a12_pulse(2);
    check_eq("short_pulse", 32'(irq), 0);
    a12_pulse(3);
    check_eq("irq_4th", 32'(irq), 1);

    // Latch 0, new mode: fires on every event
    cpu_wr(16'hE000, 8'd0);
    cpu_wr(16'hC000, 8'd0);
    cpu_wr(16'hC001, 8'd0);
    cpu_wr(16'hE001, 8'd0);
    for (int p = 0; p < 3; p++) begin
      a12_pulse(3);
      check_eq("l0_new_fire", 32'(irq), 1);
      cpu_wr(16'hE000, 8'd0);
      check_eq("l0_new_clr", 32'(irq), 0);
      cpu_wr(16'hE001, 8'd0);
    end

    // Latch 0, alt mode: fires once per reload
    irq_alt = 1'b1;
    cpu_wr(16'hE000, 8'd0);
    cpu_wr(16'hC001, 8'd0);
    cpu_wr(16'hE001, 8'd0);
    a12_pulse(3);
    check_eq("l0_alt_p1", 32'(irq), 1);
    for (int p = 0; p < 2; p++) begin
      cpu_wr(16'hE000, 8'd0);
      cpu_wr(16'hE001, 8'd0);
      a12_pulse(3);
      check_eq("l0_alt_again", 32'(irq), 0);
    end

    // Writes coinciding with a firing clock event
    irq_alt = 1'b0;
    cpu_wr(16'hE001, 8'd0);
    a12_pulse_wr(3, 16'hE000, 8'd0);
    check_eq("e000_vs_fire", 32'(irq), 0);
    a12_pulse_wr(3, 16'hE001, 8'd0);
    check_eq("e001_old_en", 32'(irq), 0);
    a12_pulse(3);
    check_eq("fire_after_e001", 32'(irq), 1);

    // Reset with ce low while irq is high
    reset = 1'b1; ce = 1'b0;
    step();
    check_eq("rst_mid_irq", 32'(irq), 0);
    check_eq("rst_outer_clr", 32'(outer_bank), 0);
    reset = 1'b0; ce = 1'b1;
    cpu_wr(16'hC000, 8'd2);
    cpu_wr(16'hE001, 8'd0);
    repeat (2) a12_pulse(3);
    check_eq("cnt_from_zero_p2", 32'(irq), 0);
    a12_pulse(3);
    check_eq("cnt_from_zero_p3", 32'(irq), 1);

    // Reload written on an event cycle stays pending
    cpu_wr(16'hE000, 8'd0);
    cpu_wr(16'hE001, 8'd0);
    a12_pulse_wr(3, 16'hC001, 8'd0);
    repeat (2) a12_pulse(3);
    check_eq("c001_pending", 32'(irq), 0);
    a12_pulse(3);
    check_eq("c001_fire", 32'(irq), 1);

    // Randomized traffic
    hold = 0;
    a12v = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      ce = ($urandom_range(0, 7) != 0);
      if (i % 500 == 0) irq_alt = 1'($urandom_range(0, 1));
      chr_ram = 1'($urandom_range(0, 1));
      if (hold == 0) begin
        a12v = ~a12v;
        hold = $urandom_range(1, 5);
      end else begin
        hold--;
      end
      chr_ain = 14'($urandom);
      chr_ain[12] = a12v;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        prg_write = 1'b1; prg_read = 1'b0;
        prg_ain = 16'h8000 | 16'($urandom);
        prg_din = ((prg_ain & 16'hE001) == 16'hC000) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      end else if (r == 2 && $urandom_range(0, 7) == 0) begin
        prg_write = 1'b1; prg_read = 1'b0;
        prg_ain = 16'h6000 | 16'($urandom_range(0, 16'h1FFF));
        prg_din = 8'($urandom);
      end else begin
        idle();
        prg_ain = 16'($urandom);
      end
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmc3_gen.md
Name: mmc3_gen

Overview:
Parametrised next-generation MMC3-family mapper for the NES core. It sits between the CPU/PPU bus decoders and the SDRAM address map, like the existing single-config MMC3. It adds:
- generic bank widths;
- a generic multicart outer-bank register with write-lock (generalising mapper 47);
- a true A12 low-time filter;
- run-time selection between new and alt IRQ counter behaviour.

Parameters:
PRG_BANK_W, 8, total 8 KB PRG bank-number width (inner + outer).
CHR_BANK_W, 8, total 1 KB CHR bank-number width (inner + outer).
OUTER_W, 2, multicart outer-bank bits; 0 disables the outer register.
A12_LOW_MIN, 3, consecutive ce cycles A12 must be low before a rising edge clocks the counter.
ADDR_W, 22, SDRAM address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce  in  1  bus clock enable; all state updates only when ce=1
irq_alt  in  1  0 = new (Sharp/MMC3C) IRQ behaviour; 1 = alt (MMC3A) behaviour
chr_ram  in  1  CHR is RAM (writable)
prg_ain  in  16  CPU address
prg_read  in  1  CPU read strobe
prg_write  in  1  CPU write strobe
prg_din  in  8  CPU write data
prg_aout  out  ADDR_W  PRG SDRAM address
prg_allow  out  1  memory access permitted
chr_ain  in  14  PPU address
chr_aout  out  ADDR_W  CHR SDRAM address
chr_allow  out  1  CHR write permitted
vram_a10  out  1  CIRAM A10
vram_ce  out  1  route access to internal VRAM (= chr_ain[13])
irq  out  1  level IRQ to CPU
outer_bank  out  max(OUTER_W,1)  current outer bank (debug/OSD)

Behaviour:
- Reset clears every register to 0. This includes bank_select, both mode bits, mirroring, irq_enable, irq_reload, latch, counter, ram_enable/protect, all bank registers, outer bank, outer lock and the A12 filter counter. irq=0 and outer_bank=0 out of reset.
- Reset dominates ce. Reset mid-IRQ drops irq the next cycle.
- CPU register map ($8000-$FFFF), decoded on {A14,A13,A0}:
  - bank select: {D7 chr invert, D6 prg mode, D2:0 index};
  - bank data for R0-R7 (R0/R1 ignore D0);
  - mirroring: D0;
  - RAM control: {D7 enable, D6 protect};
  - IRQ latch;
  - IRQ reload: sets irq_reload;
  - IRQ disable: clears irq_enable and irq;
  - IRQ enable.
- Bank data is stored with the full inner width: PRG_BANK_W-OUTER_W bits PRG, CHR_BANK_W-OUTER_W bits CHR. Excess D bits are dropped.
- Outer register (OUTER_W>0):
  - A write to $6000-$7FFF while lock=0 loads outer <= D[OUTER_W-1:0] and lock <= D7.
  - Once lock=1, writes are ignored until reset.
  - With OUTER_W>0, PRG RAM is absent and prg_allow is never set for $6000-$7FFF.
- PRG mapping:
  - inner sel = standard MMC3 quadrant table;
  - fixed banks are all-ones (last) and all-ones-minus-1 (second last) within the inner width;
  - final bank = {outer, inner}; prg_aout = zero-extended {bank, A12:0}.
- PRG RAM (OUTER_W=0):
  - $6000-$7FFF is RAM when ram_enable=1, and not (protect=1 and write);
  - it maps to the top 8 KB region of SDRAM.
- prg_allow = (A15 and read-not-write) or RAM hit.
- CHR mapping:
  - standard 2x2 KB + 4x1 KB table, XOR'd by chr invert;
  - final bank = {outer, inner}; chr_allow = chr_ram.
- vram_a10 = mirroring ? chr_ain[11] : chr_ain[10].
- Combinational outputs (aout, allow, a10) have zero latency. irq is registered.
- A12 filter:
  - lowcnt increments (saturating at A12_LOW_MIN) on each ce cycle with A12=0, and clears when A12=1.
  - A clock event occurs on a ce cycle with A12=1, A12 low on the previous ce cycle, and lowcnt==A12_LOW_MIN.
  - Shorter low pulses are ignored entirely.
- Counter, on a clock event:
  - new = (counter==0 or reload) ? latch : counter-1 (8-bit);
  - counter <= new; reload <= 0;
  - irq <= 1 if new==0 and irq_enable and (irq_alt==0 or counter!=0 or reload).
- irq asserts on the cycle after the clocking ce edge. It is cleared only by the IRQ-disable write or reset.
- Simultaneous events:
  - $C001 write on a clock-event cycle: the event consumes the old reload, and the write leaves reload=1 pending.
  - $E000 write on an IRQ-firing cycle: disable wins, irq=0.
  - $E001 write on a firing cycle: the event uses the old enable.
- Latch=0 in new mode fires on every clock event. In alt mode it fires once per reload.

Decomposition:
- Shared package mapper_pkg: register-index constants (R0-R7), quadrant decode codes, and the SDRAM region base constants for PRG RAM and CHR.
- One natural sub-module: mmc3_irq_unit, containing the A12 filter, counter, reload/enable logic and irq flop. It is reusable by the future MMC6/Rambo variants.

Test Plan:
- Reset, then read $E000 and $C000 in mode 0 -> prg_aout bank = all-ones and all-ones-1 (inner, outer=0); irq=0; outer_bank=0.
- Write $8000=$46, $8001=$05, then read $C000 -> bank 5; read $8000 -> second-last bank.
- OUTER_W=2: write $6000=$82, then $6000=$01 -> outer stays 2 (locked). PRG bank MSBs = 2'b10 and CHR bank MSBs = 2'b10; prg_allow=0 at $6000.
- Latch=3, reload, enable, valid A12 pulses (low ≥3 ce) -> irq rises one cycle after the 4th pulse. A pulse with only 2 ce low cycles does not clock the counter.
- Latch=0, reload, enable, 3 valid pulses: irq_alt=0 -> fires after pulse 1, and refires after each pulse once cleared by $E000/$E001. irq_alt=1 -> fires once only.
- $E000 write coincident with a firing clock event -> irq stays 0. Reset asserted while irq=1 -> irq=0 and counter=0 the next cycle.
